// File: rtl/half_adder_sched_pkg.sv
// Shared constants for the bit-serial addition scheduler: FSM encoding and stats width.
package half_adder_sched_pkg;

    localparam int STATE_W = 2;
    localparam int STAT_W  = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_P0   = 2'd1,
        ST_P1   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder; the only arithmetic element in the scheduler datapath.
module half_adder (
    input  logic A,
    input  logic B,
    output logic Sum,
    output logic Carry
);

    assign Sum   = A ^ B;
    assign Carry = A & B;

endmodule

// File: rtl/half_adder_sched.sv
// Round-robin scheduler sharing one half adder, two phases per bit, LSB-first ripple.
// Optional per-requester completion counters under HALF_ADDER_SCHED_STATS_EN.
module half_adder_sched
    import half_adder_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id
`ifdef HALF_ADDER_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0] stat0_cnt,
    output logic [STAT_W-1:0] stat1_cnt
`endif
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               s1_q, s1_d;
    logic               c1_q, c1_d;
    logic               id_q, id_d;
    logic               last_grant_q, last_grant_d;

    logic               grant_any;
    logic               grant_id;
    logic               accept;
    logic               res_fire;
    logic               ha_a, ha_b, ha_sum, ha_carry;

    half_adder u_half_adder (
        .A     (ha_a),
        .B     (ha_b),
        .Sum   (ha_sum),
        .Carry (ha_carry)
    );

    // On a tie the requester that did not receive the last result wins.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
        accept     = (state_q == ST_IDLE) && grant_any && rst_n;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        res_fire   = (state_q == ST_DONE) && res_ready;
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sum_d        = sum_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        s1_d         = s1_q;
        c1_d         = c1_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        ha_a         = 1'b0;
        ha_b         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = grant_id ? req1_a : req0_a;
                    b_d     = grant_id ? req1_b : req0_b;
                    id_d    = grant_id;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ST_P0;
                end
            end
            ST_P0: begin
                ha_a    = a_q[idx_q];
                ha_b    = b_q[idx_q];
                s1_d    = ha_sum;
                c1_d    = ha_carry;
                state_d = ST_P1;
            end
            ST_P1: begin
                // c1 and this carry are mutually exclusive, so OR is the full-adder carry.
                ha_a         = s1_q;
                ha_b         = carry_q;
                sum_d[idx_q] = ha_sum;
                carry_d      = c1_q | ha_carry;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_P0;
                end
            end
            ST_DONE: begin
                if (res_fire) begin
                    last_grant_d = id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            s1_q         <= 1'b0;
            c1_q         <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sum_q        <= sum_d;
            idx_q        <= idx_d;
            carry_q      <= carry_d;
            s1_q         <= s1_d;
            c1_q         <= c1_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = (state_q == ST_DONE);
    assign res_sum   = sum_q;
    assign res_carry = carry_q;
    assign res_id    = id_q;

`ifdef HALF_ADDER_SCHED_STATS_EN
    logic [STAT_W-1:0] stat0_q, stat0_d;
    logic [STAT_W-1:0] stat1_q, stat1_d;

    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (res_fire) begin
            if (id_q) begin
                stat1_d = stat1_q + 1'b1;
            end else begin
                stat0_d = stat0_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat0_cnt = stat0_q;
    assign stat1_cnt = stat1_q;
`endif

endmodule

// File: tb/tb_half_adder_sched.sv
// Directed bench for half_adder_sched (WIDTH=8); stats checks build when HALF_ADDER_SCHED_STATS_EN is defined.
module tb_half_adder_sched;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic         res_valid, res_ready;
    logic [W-1:0] res_sum;
    logic         res_carry, res_id;
`ifdef HALF_ADDER_SCHED_STATS_EN
    logic [15:0]  stat0_cnt, stat1_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    half_adder_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_id     (res_id)
`ifdef HALF_ADDER_SCHED_STATS_EN
        ,
        .stat0_cnt  (stat0_cnt),
        .stat1_cnt  (stat1_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits, sampling at negedges, until res_valid; lat counts posedges elapsed.
    task automatic wait_result(inout int lat, output bit to);
        to = 1'b0;
        while (!res_valid) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat > 200) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    // Drives one operand pair to completion; lat is the cycle res_valid is first seen (accept = cycle 0).
    task automatic run_txn(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] sum, output logic c, output logic rid,
                           output int lat, output bit to);
        int n;
        to  = 1'b0;
        lat = 0;
        sum = '0;
        c   = 1'b0;
        rid = 1'b0;
        @(negedge clk);
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready)) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 200) begin
                to = 1'b1;
                break;
            end
        end
        if (to) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
        wait_result(lat, to);
        if (to) return;
        sum = res_sum;
        c   = res_carry;
        rid = res_id;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 8'h12; req0_b = 8'h34; req1_a = 8'h56; req1_b = 8'h78;
        res_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if ({req0_ready, req1_ready, res_valid, res_sum, res_carry, res_id} !== '0) begin
                n_err++;
                $display("FAIL reset cycle %0d: r0=%b r1=%b v=%b sum=%h c=%b id=%b, required all 0",
                         i, req0_ready, req1_ready, res_valid, res_sum, res_carry, res_id);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [W-1:0] s; logic c, rid; int lat; bit to;
        run_txn(1'b0, 8'h0F, 8'h01, s, c, rid, lat, to);
        n_vec++;
        if (to) begin n_err++; $display("FAIL basic timeout"); return; end
        if ({s, c, rid} !== {8'h10, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL basic 0F+01: sum=%h c=%b id=%b, required 10 0 0", s, c, rid);
        end
        n_vec++;
        if (lat !== 17) begin
            n_err++;
            $display("FAIL basic latency: got %0d, required 17", lat);
        end
    endtask

    task automatic test_boundary;
        logic [W-1:0] s; logic c, rid; int lat; bit to;
        run_txn(1'b0, 8'hFF, 8'h01, s, c, rid, lat, to);
        n_vec++;
        if (to || s !== 8'h00 || c !== 1'b1) begin
            n_err++;
            $display("FAIL boundary FF+01: sum=%h c=%b to=%b, required 00 1", s, c, to);
        end
        run_txn(1'b0, 8'h00, 8'h00, s, c, rid, lat, to);
        n_vec++;
        if (to || s !== 8'h00 || c !== 1'b0) begin
            n_err++;
            $display("FAIL boundary 00+00: sum=%h c=%b to=%b, required 00 0", s, c, to);
        end
        run_txn(1'b1, 8'h80, 8'h80, s, c, rid, lat, to);
        n_vec++;
        if (to || s !== 8'h00 || c !== 1'b1 || rid !== 1'b1) begin
            n_err++;
            $display("FAIL boundary 80+80 req1: sum=%h c=%b id=%b, required 00 1 1", s, c, rid);
        end
    endtask

    task automatic test_back_to_back;
        int lat; bit to;
        apply_reset(2);
        @(negedge clk);
        res_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h05;
        req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55;
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL rr first grant: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        wait_result(lat, to);
        n_vec++;
        if (to || res_sum !== 8'h08 || res_carry !== 1'b0 || res_id !== 1'b0) begin
            n_err++;
            $display("FAIL rr result0: sum=%h c=%b id=%b, required 08 0 0", res_sum, res_carry, res_id);
        end
        n_vec++;
        if (req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rr busy ready: r1=%b, required 0", req1_ready);
        end
        // req0 still valid for a new pair: req1 must win the tie next.
        req0_a = 8'h10; req0_b = 8'h20;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rr second grant: r0=%b r1=%b, required 0 1", req0_ready, req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        lat = 1;
        wait_result(lat, to);
        n_vec++;
        if (to || res_sum !== 8'hFF || res_carry !== 1'b0 || res_id !== 1'b1) begin
            n_err++;
            $display("FAIL rr result1: sum=%h c=%b id=%b, required FF 0 1", res_sum, res_carry, res_id);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL rr third grant: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        lat = 1;
        wait_result(lat, to);
        n_vec++;
        if (to || res_sum !== 8'h30 || res_id !== 1'b0) begin
            n_err++;
            $display("FAIL rr result2: sum=%h id=%b, required 30 0", res_sum, res_id);
        end
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_stall_and_abort;
        int lat; bit to; bit bad;
        apply_reset(1);
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h44; req1_b = 8'h44;
        lat = 1;
        wait_result(lat, to);
        bad = to;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (res_valid !== 1'b1 || res_sum !== 8'h03 || res_id !== 1'b0 || req1_ready !== 1'b0)
                bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL stall hold: v=%b sum=%h id=%b r1=%b, required 1 03 0 0",
                     res_valid, res_sum, res_id, req1_ready);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready  = 1'b0;
        req1_valid = 1'b0;
        // Abort: accept a req0 pair, reset during P0 of bit 3 (cycle 7).
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
        @(posedge clk);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (req0_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort ready in reset: r0=%b, required 0", req0_ready);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b0 || res_sum !== 8'h00) begin
            n_err++;
            $display("FAIL abort outputs: v=%b sum=%h, required 0 00", res_valid, res_sum);
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort regrant: r0=%b, required 1", req0_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        lat = 1;
        wait_result(lat, to);
        n_vec++;
        if (to || res_sum !== 8'h33 || res_id !== 1'b0 || lat !== 17) begin
            n_err++;
            $display("FAIL abort rerun: sum=%h id=%b lat=%0d, required 33 0 17", res_sum, res_id, lat);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

`ifdef HALF_ADDER_SCHED_STATS_EN
    task automatic test_stats;
        logic [W-1:0] s; logic c, rid; int lat; bit to;
        apply_reset(1);
        for (int i = 0; i < 3; i++) run_txn(1'b0, 8'(i), 8'h01, s, c, rid, lat, to);
        for (int i = 0; i < 2; i++) run_txn(1'b1, 8'(i), 8'h02, s, c, rid, lat, to);
        @(negedge clk);
        n_vec++;
        if (stat0_cnt !== 16'd3 || stat1_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL stats counts: s0=%0d s1=%0d, required 3 2", stat0_cnt, stat1_cnt);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_stall_and_abort();
`ifdef HALF_ADDER_SCHED_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
